// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencing controller for the MIPS core: steps each instruction through
// fetch/decode/execute/memory/write-back and drives every datapath enable and select.
module mips_multicycle_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  op_code,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        pc_en,
    output logic [1:0]  pc_source,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_sel,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10
    } state_t;

    state_t cur, nxt;

    logic is_rtype, is_jr, is_load, is_store, is_imm, is_branch, is_jump, is_jal;
    logic retire_c;

    assign is_rtype  = (op_code == 6'b000000);
    assign is_jr     = is_rtype && (funct == 6'b001000);
    assign is_load   = (op_code == 6'b100011) || (op_code == 6'b100001) || (op_code == 6'b100000);
    assign is_store  = (op_code == 6'b101011) || (op_code == 6'b101001) || (op_code == 6'b101000);
    assign is_imm    = (op_code == 6'b001000) || (op_code == 6'b001010) || (op_code == 6'b001011) ||
                       (op_code == 6'b001100) || (op_code == 6'b001101) || (op_code == 6'b001111);
    assign is_branch = (op_code == 6'b000100) || (op_code == 6'b000101);
    assign is_jal    = (op_code == 6'b000011);
    assign is_jump   = (op_code == 6'b000010) || is_jal;

    assign state = cur;

    // Next state and per-state control; strobes are gated off while reset is high.
    always_comb begin
        nxt        = cur;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_sel    = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 2'b00;
        illegal    = 1'b0;
        unique case (cur)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (is_load || is_store) nxt = S_MEM_ADDR;
                else if (is_jr)          nxt = S_JUMP;
                else if (is_rtype)       nxt = S_EXEC_R;
                else if (is_imm)         nxt = S_EXEC_I;
                else if (is_branch)      nxt = S_BRANCH;
                else if (is_jump)        nxt = S_JUMP;
                else begin
                    nxt     = S_FETCH;
                    illegal = 1'b1;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt       = is_store ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b11;
                nxt        = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_sel   = 2'b10;
                nxt       = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = 2'b10;
                nxt       = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = is_rtype ? 2'b11 : 2'b00;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_sel   = 2'b01;
                pc_source = 2'b01;
                pc_en     = (op_code == 6'b000101) ? ~zero : zero;
                nxt       = S_FETCH;
            end
            S_JUMP: begin
                pc_en = 1'b1;
                if (is_jr) begin
                    pc_source = 2'b11;
                end else begin
                    pc_source = 2'b10;
                    if (is_jal) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'b01;
                        mem_to_reg = 2'b01;
                    end
                end
                nxt = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
        if (reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    // An instruction completes on any return to FETCH except the illegal-opcode path.
    assign retire_c = (nxt == S_FETCH) && (cur != S_FETCH) && (cur != S_DECODE);

    always_ff @(posedge clock) begin
        if (reset) begin
            cur     <= S_FETCH;
            retired <= 32'd0;
        end else begin
            cur <= nxt;
            if (retire_c) retired <= retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-level bench for mips_multicycle_ctrl with a phase-list reference model.
module tb_mips_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  op_code, funct;
    logic        zero, mem_ready;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_en, alu_src_a, reg_write, illegal;
    logic [1:0]  pc_source, alu_src_b, alu_sel, reg_dst, mem_to_reg;
    logic [3:0]  state;
    logic [31:0] retired;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_retired = 32'd0;

    always #5 clock = ~clock;

    mips_multicycle_ctrl dut (
        .clock(clock), .reset(reset), .op_code(op_code), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_sel(alu_sel), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state), .retired(retired)
    );

    // Control outputs packed in port order for one-shot comparison.
    wire [17:0] ctrl_act = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
                            alu_src_b, alu_sel, reg_write, reg_dst, mem_to_reg, illegal};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Instruction classes: 0 R, 1 I, 2 load, 3 store, 4 branch, 5 jump, 6 illegal.
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000:                                     return (fn == 6'b001000) ? 5 : 0;
            6'b001000, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001111:               return 1;
            6'b100011, 6'b100001, 6'b100000:               return 2;
            6'b101011, 6'b101001, 6'b101000:               return 3;
            6'b000100, 6'b000101:                          return 4;
            6'b000010, 6'b000011:                          return 5;
            default:                                       return 6;
        endcase
    endfunction

    // Expected control word for a given state number, straight from the state table.
    function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] op, input logic [5:0] fn,
                                             input logic z, input logic rdy, input logic rst);
        logic mr = 0, mw = 0, iod = 0, irw = 0, pce = 0, asa = 0, rw = 0, ill = 0;
        logic [1:0] pcs = 0, asb = 0, sel = 0, rd = 0, m2r = 0;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pce = rdy; end
            1:  begin asb = 2'b11; ill = (classify(op, fn) == 6); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 2'b11; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; sel = 2'b10; end
            7:  begin asa = 1; asb = 2'b10; sel = 2'b10; end
            8:  begin rw = 1; rd = (op == 0) ? 2'b11 : 2'b00; end
            9:  begin asa = 1; sel = 2'b01; pcs = 2'b01; pce = (op == 6'b000101) ? !z : z; end
            10: begin
                pce = 1;
                if (op == 0) pcs = 2'b11;
                else begin
                    pcs = 2'b10;
                    if (op == 6'b000011) begin rw = 1; rd = 2'b01; m2r = 2'b01; end
                end
            end
            default: ;
        endcase
        if (rst) begin mr = 0; mw = 0; irw = 0; pce = 0; rw = 0; ill = 0; end
        return {mr, mw, iod, irw, pce, pcs, asa, asb, sel, rw, rd, m2r, ill};
    endfunction

    // One cycle: apply mem_ready, check state and controls, advance to the next edge.
    task automatic step(input int st, input logic rdy);
        mem_ready = rdy;
        #1;
        check("state", 32'(state), 32'(st));
        check("ctrl", 32'(ctrl_act), 32'(exp_ctrl(st, op_code, funct, zero, rdy, reset)));
        @(posedge clock);
        #1;
    endtask

    // Run one instruction; wf/wm are wait cycles on fetch and on the data access.
    // With abort set, reset is raised during the first MEM_WRITE cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm, input bit abort);
        int cls;
        int ph[$];
        op_code = op; funct = fn; zero = z;
        cls = classify(op, fn);
        #0;
        check("retired", retired, exp_retired);
        case (cls)
            0: ph = '{6, 8};
            1: ph = '{7, 8};
            2: ph = '{2, 3, 4};
            3: ph = '{2, 5};
            4: ph = '{9};
            5: ph = '{10};
            default: ph = {};
        endcase
        for (int i = 0; i < wf; i++) step(0, 1'b0);
        step(0, 1'b1);
        step(1, 1'($urandom));
        foreach (ph[k]) begin
            if (ph[k] == 3 || ph[k] == 5) begin
                if (abort && ph[k] == 5) begin
                    reset = 1'b1;
                    step(5, 1'b0);
                    check("abort_state", 32'(state), 32'd0);
                    check("abort_retired", retired, 32'd0);
                    reset = 1'b0;
                    exp_retired = 32'd0;
                    return;
                end
                for (int i = 0; i < wm; i++) step(ph[k], 1'b0);
                step(ph[k], 1'b1);
            end else begin
                step(ph[k], 1'($urandom));
            end
        end
        if (cls != 6) exp_retired = exp_retired + 32'd1;
    endtask

    logic [5:0] legal_ops [0:18] = '{6'h00, 6'h00, 6'h08, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f,
                                     6'h23, 6'h21, 6'h20, 6'h2b, 6'h29, 6'h28, 6'h04, 6'h05,
                                     6'h02, 6'h03, 6'h3f};

    initial begin
        logic [5:0] op, fn;
        reset = 1'b1; mem_ready = 1'b1; op_code = 6'd0; funct = 6'd0; zero = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_state", 32'(state), 32'd0);
            check("rst_retired", retired, 32'd0);
            check("rst_ctrl", 32'(ctrl_act), 32'(exp_ctrl(0, op_code, funct, zero, 1'b1, 1'b1)));
            @(posedge clock); #1;
        end
        reset = 1'b0;

        run_instr(6'h00, 6'b100000, 1'b0, 0, 0, 1'b0);   // add
        run_instr(6'h23, 6'h00, 1'b0, 0, 2, 1'b0);       // lw, 2-cycle read stall
        run_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);       // beq taken
        run_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b0);       // bne not taken
        run_instr(6'h03, 6'h00, 1'b0, 1, 0, 1'b0);       // jal
        run_instr(6'h00, 6'b001000, 1'b0, 0, 0, 1'b0);   // jr
        run_instr(6'h3f, 6'h00, 1'b0, 0, 0, 1'b0);       // illegal
        run_instr(6'h2b, 6'h00, 1'b0, 0, 1, 1'b1);       // sw aborted by reset

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, 18)];
            fn = ($urandom_range(0, 5) == 0) ? 6'b001000 : 6'($urandom);
            run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end
        #1;
        check("final_retired", retired, exp_retired);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
